// File: rtl/cpu_sequencer_if.sv
// Host/cpu-side bus of the program sequencer.
// The master side loads the program and controls execution.
// The slave side (the sequencer) drives the instruction stream and status back.
interface cpu_sequencer_if #(
  parameter int ADDR_W = 4
);
  // program load and run control
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [12:0]       prog_data;
  logic [ADDR_W:0]   prog_len;
  logic              start;
  logic              step_mode;
  logic              step;
  logic              abort;

  // instruction stream and status
  logic [12:0]       instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic              prog_err;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len,
    output start, step_mode, step, abort,
    input  instr, instr_valid, pc, busy, done, prog_err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len,
    input  start, step_mode, step, abort,
    output instr, instr_valid, pc, busy, done, prog_err
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Program sequencer for the 8-bit cpu core.
// A small instruction memory is loaded by the host while idle. After start,
// the memory is read in address order. Each word is held on the instr bus for
// the number of cycles its addressing mode needs. Execution ends at the end of
// the program, at a HALT word, or on abort. Single-step pausing is available
// for debug. All outputs come straight from registers.
module cpu_sequencer #(
  parameter int          DEPTH      = 16,
  parameter int          ADDR_W     = 4,
  parameter int          IMM_CYCLES = 1,
  parameter int          REG_CYCLES = 2,
  parameter logic [12:0] HALT_WORD  = 13'h1FFF
) (
  input  logic          clk,
  input  logic          reset,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The hold counter only has to reach (longest issue time - 1).
  localparam int MAX_CYC = (IMM_CYCLES > REG_CYCLES) ? IMM_CYCLES : REG_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

  // Extra issue cycles after the first one, selected by the mode bit.
  function automatic logic [CNT_W-1:0] hold_count(input logic [12:0] word);
    logic [CNT_W-1:0] cnt_v;
    if (word[12]) begin
      cnt_v = CNT_W'(IMM_CYCLES - 1);
    end else begin
      cnt_v = CNT_W'(REG_CYCLES - 1);
    end
    return cnt_v;
  endfunction

  // A program can never run past the end of the memory.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    logic [ADDR_W:0] len_v;
    if (len > DEPTH_L) begin
      len_v = DEPTH_L;
    end else begin
      len_v = len;
    end
    return len_v;
  endfunction

  logic [12:0]       mem_r [DEPTH];

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [12:0]       instr_r;
  logic [12:0]       instr_nxt_s;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   len_nxt_s;
  logic [ADDR_W:0]   start_len_s;
  logic              valid_r;
  logic              valid_nxt_s;
  logic              busy_r;
  logic              busy_nxt_s;
  logic              done_r;
  logic              done_nxt_s;
  logic              perr_r;
  logic              perr_nxt_s;
  logic              write_ok_s;
  logic [12:0]       word_s;
  logic              last_s;

  // Writes are only accepted while idle and within the memory range.
  assign write_ok_s = bus.prog_we && (state_r == ST_IDLE) &&
                      ({1'b0, bus.prog_addr} < DEPTH_L);

  // The word under pc is read during FETCH; a write in the start cycle has
  // already landed by then, so the first fetch sees the new data.
  assign word_s = mem_r[pc_r];

  // pc addresses the final instruction of the latched program length.
  assign last_s = ({1'b0, pc_r} == (len_r - ONE_L));

  assign start_len_s = clamp_len(bus.prog_len);

  // Instruction memory: host writes only; contents survive reset.
  always_ff @(posedge clk) begin
    if (write_ok_s) begin
      mem_r[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    cnt_nxt_s   = cnt_r;
    instr_nxt_s = instr_r;
    len_nxt_s   = len_r;

    if ((state_r != ST_IDLE) && bus.abort) begin
      // abort beats every other transition, including step and end of program
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            len_nxt_s = start_len_s;
            if (start_len_s != {(ADDR_W + 1){1'b0}}) begin
              state_nxt_s = ST_FETCH;
              pc_nxt_s    = {ADDR_W{1'b0}};
            end else begin
              state_nxt_s = ST_DONE;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end

        ST_FETCH: begin
          if (word_s == HALT_WORD) begin
            // HALT is never put on the bus; pc keeps pointing at it
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ISSUE;
            instr_nxt_s = word_s;
            cnt_nxt_s   = hold_count(word_s);
          end
        end

        ST_ISSUE: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
          end else if (last_s) begin
            state_nxt_s = ST_DONE;
          end else if (bus.step_mode) begin
            state_nxt_s = ST_PAUSE;
          end else begin
            state_nxt_s = ST_FETCH;
            pc_nxt_s    = pc_r + ADDR_W'(1);
          end
        end

        ST_PAUSE: begin
          if (bus.step) begin
            state_nxt_s = ST_FETCH;
            pc_nxt_s    = pc_r + ADDR_W'(1);
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end

        ST_DONE: begin
          state_nxt_s = ST_IDLE;
        end

        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end

    // outputs are decoded from the next state so they line up with it
    valid_nxt_s = (state_nxt_s == ST_ISSUE);
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    done_nxt_s  = (state_nxt_s == ST_DONE);
    perr_nxt_s  = bus.prog_we && (state_r != ST_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pc_r    <= {ADDR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      instr_r <= 13'h0000;
      len_r   <= {(ADDR_W + 1){1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      perr_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      instr_r <= instr_nxt_s;
      len_r   <= len_nxt_s;
      valid_r <= valid_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      perr_r  <= perr_nxt_s;
    end
  end

  assign bus.instr       = instr_r;
  assign bus.instr_valid = valid_r;
  assign bus.pc          = pc_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.prog_err    = perr_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer. A reference schedule of issued words is built from
// the bench's own copy of the program memory when a run starts. A monitor on the
// falling edge pops and compares every valid instruction against it.
module tb_cpu_sequencer;

  localparam logic [12:0] HALT = 13'h1FFF;

  typedef struct {
    int          cyc;
    logic [3:0]  pc;
    logic [12:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  exp_t        sbq[$];
  exp_t        e;
  logic [12:0] mem_img [16];

  int n_chk;
  int n_pass;
  int pcnt;
  int t0;
  int rel;
  int exp_done;
  int exp_perr;
  int exp_end;
  int exp_pc;
  int done_cnt;
  int perr_cnt;
  bit mon_en;
  bit chk_cyc;

  cpu_sequencer_if #(.ADDR_W(4)) bus_if ();

  cpu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter used to time-stamp monitor observations
  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  // monitor: valid instructions, done pulses and write-rejection pulses
  always @(negedge clk) begin
    if (mon_en) begin
      rel = pcnt - t0;
      if (bus_if.instr_valid) begin
        if (sbq.size() == 0) begin
          chk("extra_valid", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("instr", 32'(bus_if.instr), 32'(e.instr));
          chk("pc", 32'(bus_if.pc), 32'(e.pc));
          if (chk_cyc) chk("valid_cyc", 32'(rel), 32'(e.cyc));
        end
      end
      if (bus_if.done) begin
        done_cnt++;
        if (chk_cyc) chk("done_cyc", 32'(rel), 32'(exp_done));
      end
      if (bus_if.prog_err) begin
        perr_cnt++;
        chk("perr_cyc", 32'(rel), 32'(exp_perr));
      end
    end
  end

  // Reference schedule: fetch takes a cycle, then the word is valid for 1
  // (immediate) or 2 (register) cycles; HALT or the last word ends the run.
  task automatic build_expect(input int len, input int abort_cyc);
    int   c;
    int   p;
    int   l;
    int   nc;
    exp_t x;
    sbq.delete();
    done_cnt = 0;
    perr_cnt = 0;
    exp_perr = -1;
    exp_pc   = 0;
    l = (len > 16) ? 16 : len;
    c = 1;
    p = 0;
    if (l == 0) begin
      exp_done = 1;
    end else begin
      forever begin
        if (mem_img[p] == HALT) begin
          exp_done = c + 1;
          exp_pc   = p;
          break;
        end
        nc = mem_img[p][12] ? 1 : 2;
        for (int k = 0; k < nc; k++) begin
          if (abort_cyc < 0 || (c + 1 + k) <= abort_cyc) begin
            x.cyc   = c + 1 + k;
            x.pc    = 4'(p);
            x.instr = mem_img[p];
            sbq.push_back(x);
          end
        end
        if (p == l - 1) begin
          exp_done = c + nc + 1;
          exp_pc   = p;
          break;
        end
        p++;
        c = c + nc + 1;
      end
    end
    if (abort_cyc >= 0) begin
      exp_done = -1;
      exp_end  = abort_cyc + 1;
    end else begin
      exp_end = exp_done + 1;
    end
  endtask

  task automatic write_mem(input int addr, input logic [12:0] data);
    @(posedge clk); #1;
    bus_if.prog_we   = 1'b1;
    bus_if.prog_addr = 4'(addr);
    bus_if.prog_data = data;
    @(posedge clk); #1;
    bus_if.prog_we = 1'b0;
    mem_img[addr]  = data;
  endtask

  // start asserted for one cycle (cycle 0); returns at the start of cycle 1
  task automatic start_pulse(input int len);
    @(posedge clk); #1;
    bus_if.prog_len = 5'(len);
    bus_if.start    = 1'b1;
    t0 = pcnt;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  // One run with optional abort cycle and optional rejected-write cycle.
  task automatic run_prog(input int len, input int abort_cyc, input int wr_cyc);
    int n;
    bit finished;
    build_expect(len, abort_cyc);
    if (wr_cyc >= 0) exp_perr = wr_cyc + 1;
    chk_cyc  = 1'b1;
    finished = 1'b0;
    start_pulse(len);
    for (n = 1; n < 300; n++) begin
      bus_if.abort     = (n == abort_cyc);
      bus_if.prog_we   = (n == wr_cyc);
      bus_if.prog_addr = 4'd0;
      bus_if.prog_data = 13'h0AAA;
      @(negedge clk);
      if (!bus_if.busy) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus_if.abort   = 1'b0;
    bus_if.prog_we = 1'b0;
    chk("run_timeout", 32'(finished), 32'd1);
    chk("end_cyc", 32'(n), 32'(exp_end));
    chk("valid_after_end", 32'(bus_if.instr_valid), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("done_cnt", 32'(done_cnt), (abort_cyc >= 0) ? 32'd0 : 32'd1);
    chk("perr_cnt", 32'(perr_cnt), (wr_cyc >= 0) ? 32'd1 : 32'd0);
    if (abort_cyc < 0 && len > 0) chk("final_pc", 32'(bus_if.pc), 32'(exp_pc));
  endtask

  task automatic wait_valid(input logic v, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_if.instr_valid === v) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; pcnt = 0; t0 = 0;
    mon_en = 1'b0; chk_cyc = 1'b1;
    exp_done = -1; exp_perr = -1;
    reset = 1'b1;
    bus_if.prog_we = 1'b0; bus_if.prog_addr = 4'd0; bus_if.prog_data = 13'h0000;
    bus_if.prog_len = 5'd0; bus_if.start = 1'b0; bus_if.step_mode = 1'b0;
    bus_if.step = 1'b0; bus_if.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_instr", 32'(bus_if.instr), 32'd0);
    chk("rst_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("rst_pc", 32'(bus_if.pc), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_perr", 32'(bus_if.prog_err), 32'd0);

    write_mem(0, 13'b1_011_0_00000100);
    write_mem(1, 13'b1_010_0_00000011);
    write_mem(2, 13'b0_011_010_001_010);
    mon_en = 1'b1;

    // basic three-instruction program
    run_prog(3, -1, -1);

    // HALT in slot 1 stops after mem0
    write_mem(1, HALT);
    run_prog(3, -1, -1);
    write_mem(1, 13'b1_010_0_00000011);

    // single-step: pause after each issue until step
    bus_if.step_mode = 1'b1;
    build_expect(3, -1);
    chk_cyc = 1'b0;
    start_pulse(3);
    for (int k = 0; k < 3; k++) begin
      wait_valid(1'b1, "step_valid_on");
      wait_valid(1'b0, "step_valid_off");
      if (k < 2) begin
        repeat (4) begin
          @(negedge clk);
          chk("pause_valid", 32'(bus_if.instr_valid), 32'd0);
          chk("pause_busy", 32'(bus_if.busy), 32'd1);
          chk("pause_pc", 32'(bus_if.pc), 32'(k));
          chk("pause_no_done", 32'(done_cnt), 32'd0);
        end
        @(posedge clk); #1 bus_if.step = 1'b1;
        @(posedge clk); #1 bus_if.step = 1'b0;
      end
    end
    begin
      bit idle_seen;
      idle_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!bus_if.busy) begin
          idle_seen = 1'b1;
          break;
        end
      end
      chk("step_end", 32'(idle_seen), 32'd1);
    end
    chk("step_done_cnt", 32'(done_cnt), 32'd1);
    chk("step_sb_empty", 32'(sbq.size()), 32'd0);
    bus_if.step_mode = 1'b0;

    // abort in the second issue cycle of mem2, then a clean rerun
    run_prog(3, 7, -1);
    run_prog(3, -1, -1);

    // write during execution is rejected; rerun shows memory intact
    run_prog(3, -1, 3);
    run_prog(3, -1, -1);

    // empty program
    run_prog(0, -1, -1);

    // length above the memory size is clamped to 16 entries
    for (int i = 3; i < 16; i++) begin
      logic [12:0] w;
      w = (i % 2 == 1) ? {1'b1, 12'(i)} : {1'b0, 12'(i * 3)};
      write_mem(i, w);
    end
    run_prog(31, -1, -1);

    // reset while mem2 is on the bus
    mon_en = 1'b0;
    start_pulse(3);
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus_if.instr_valid), 32'd1);
    chk("pre_rst_instr", 32'(bus_if.instr), 32'(mem_img[2]));
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_instr", 32'(bus_if.instr), 32'd0);
    chk("mid_rst_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("mid_rst_pc", 32'(bus_if.pc), 32'd0);
    chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    chk("mid_rst_done", 32'(bus_if.done), 32'd0);
    chk("mid_rst_perr", 32'(bus_if.prog_err), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    run_prog(3, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
